rec_lock_ctrl: RTL

Lock controller for the bit clock recovery datapath. It runs on the 300 MHz global base clock and takes per-edge interval measurements from the recovery datapath. It sequences acquisition, verification, locked tracking and loss recovery, and loads the recovered half/full period into the clock divider. It also owns the polarity-flip and divider-type requests that come from the debounced front-panel keys.

---
 rtl/rec_ctrl_pkg.sv | 19 +
 rtl/rec_min_tracker.sv | 39 +++
 rtl/rec_lock_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/rec_ctrl_pkg.sv
// Shared types and helpers for the bit clock recovery lock controller.
package rec_ctrl_pkg;

  localparam int unsigned CLK_LEN = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACQUIRE = 3'd1,
    VERIFY  = 3'd2,
    LOCKED  = 3'd3,
    LOST    = 3'd4
  } rec_state_t;

  // Clamped subtraction used for the period - tolerance threshold.
  function automatic logic [63:0] sat_sub(input logic [63:0] a, input logic [63:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/rec_min_tracker.sv
// Running minimum / valid-edge counter used while acquiring the bit period.
module rec_min_tracker #(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             valid,
  input  logic [W-1:0]     interval,
  output logic [W-1:0]     min_val,
  output logic [CNT_W-1:0] edge_cnt
);

  logic [W-1:0]     min_q;
  logic [CNT_W-1:0] cnt_q;

  // Outputs already include the edge presented this cycle so the caller can
  // load the final minimum on the same edge that completes the count.
  always_comb begin
    min_val  = min_q;
    edge_cnt = cnt_q;
    if (valid) begin
      if (interval < min_q) min_val = interval;
      if (cnt_q != '1)      edge_cnt = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      min_q <= '1;
      cnt_q <= '0;
    end else begin
      min_q <= min_val;
      cnt_q <= edge_cnt;
    end
  end

endmodule

// File: rtl/rec_lock_ctrl.sv
// Lock controller for bit clock recovery: acquire, verify, track, recover.
// Optional feature macro RECCTRL_DRIFT_EN enables slow upward period relax while locked.
module rec_lock_ctrl
  import rec_ctrl_pkg::*;
#(
  parameter int unsigned CLK_LEN      = rec_ctrl_pkg::CLK_LEN,
  parameter int unsigned INIT_PERIOD  = 801,
  parameter int unsigned MIN_INTERVAL = 3,
  parameter int unsigned ACQ_EDGES    = 16,
  parameter int unsigned VERIFY_EDGES = 32,
  parameter int unsigned TOL_SHIFT    = 3,
  parameter int unsigned SLIP_MAX     = 4,
  parameter int unsigned TIMEOUT_MULT = 64,
  parameter int unsigned DRIFT_EDGES  = 255
) (
  input  logic               clk_300M,
  input  logic               rst_n,
  input  logic               edge_pulse,
  input  logic [CLK_LEN-1:0] interval,
  input  logic               rev_req,
  input  logic               type_req,
  output logic [CLK_LEN-1:0] period_val,
  output logic               period_ld,
  output logic               clear_req,
  output logic               phase_flip,
  output logic               type_sel,
  output logic               locked,
  output logic [2:0]         state
);

  localparam int unsigned ACQ_W  = $clog2(ACQ_EDGES + 1);
  localparam int unsigned GOOD_W = $clog2(VERIFY_EDGES + 1);
  localparam int unsigned SLIP_W = $clog2(SLIP_MAX + 1);
  localparam int unsigned PW     = 2 * CLK_LEN;

  rec_state_t         state_q, state_d;
  logic [CLK_LEN-1:0] period_q, period_d;
  logic               period_ld_q, period_ld_d;
  logic               clear_q, clear_d;
  logic               flip_q, flip_d;
  logic               type_q, type_d;
  logic               locked_q, locked_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [SLIP_W-1:0]  slip_q, slip_d;
  logic [CLK_LEN-1:0] sil_q, sil_d;

  logic               valid_edge;
  logic [CLK_LEN-1:0] tol, thresh, limit;
  logic [PW-1:0]      prod;
  logic               timeout;
  logic [CLK_LEN-1:0] trk_min;
  logic [ACQ_W-1:0]   trk_cnt;

`ifdef RECCTRL_DRIFT_EN
  localparam int unsigned DRIFT_W = $clog2(DRIFT_EDGES + 1);
  logic [DRIFT_W-1:0] drift_q, drift_d;
`endif

  assign valid_edge = edge_pulse && (interval >= CLK_LEN'(MIN_INTERVAL));

  rec_min_tracker #(
    .W     (CLK_LEN),
    .CNT_W (ACQ_W)
  ) u_min_tracker (
    .clk      (clk_300M),
    .rst_n    (rst_n),
    .clr      (state_q != ACQUIRE),
    .valid    (valid_edge),
    .interval (interval),
    .min_val  (trk_min),
    .edge_cnt (trk_cnt)
  );

  always_comb begin
    tol    = period_q >> TOL_SHIFT;
    thresh = CLK_LEN'(sat_sub(64'(period_q), 64'(tol)));
    prod   = PW'(period_q) * PW'(TIMEOUT_MULT);
    limit  = (|prod[PW-1:CLK_LEN]) ? '1 : prod[CLK_LEN-1:0];

    state_d     = state_q;
    period_d    = period_q;
    period_ld_d = 1'b0;
    clear_d     = 1'b0;
    good_d      = good_q;
    slip_d      = slip_q;
    flip_d      = rev_req;
    type_d      = type_q ^ type_req;

    sil_d = '0;
    if (state_q == VERIFY || state_q == LOCKED) begin
      if (!edge_pulse) sil_d = (sil_q == '1) ? sil_q : sil_q + CLK_LEN'(1);
    end
    // Any edge clears the count, so an edge always beats the threshold.
    timeout = (state_q == VERIFY || state_q == LOCKED) && !edge_pulse && (sil_d >= limit);

`ifdef RECCTRL_DRIFT_EN
    drift_d = (state_q == LOCKED) ? drift_q : '0;
`endif

    case (state_q)
      IDLE: begin
        clear_d = 1'b1;
        state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (valid_edge && trk_cnt == ACQ_W'(ACQ_EDGES)) begin
          period_d    = trk_min;
          period_ld_d = 1'b1;
          good_d      = '0;
          state_d     = VERIFY;
        end
      end
      VERIFY: begin
        if (valid_edge) begin
          if (interval >= thresh) begin
            good_d = good_q + GOOD_W'(1);
            if (good_d == GOOD_W'(VERIFY_EDGES)) begin
              slip_d  = '0;
              state_d = LOCKED;
            end
          end else begin
            period_d    = interval;
            period_ld_d = 1'b1;
            good_d      = '0;
          end
        end
      end
      LOCKED: begin
        if (valid_edge) begin
          if (interval < thresh) begin
            slip_d = slip_q + SLIP_W'(1);
`ifdef RECCTRL_DRIFT_EN
            drift_d = '0;
`endif
            if (slip_d == SLIP_W'(SLIP_MAX)) begin
              slip_d  = '0;
              state_d = ACQUIRE;
            end
          end else begin
            slip_d = '0;
`ifdef RECCTRL_DRIFT_EN
            if (drift_q + DRIFT_W'(1) == DRIFT_W'(DRIFT_EDGES)) begin
              drift_d     = '0;
              period_d    = (period_q == '1) ? period_q : period_q + CLK_LEN'(1);
              period_ld_d = 1'b1;
            end else begin
              drift_d = drift_q + DRIFT_W'(1);
            end
`endif
          end
        end
      end
      LOST: begin
        clear_d     = 1'b1;
        period_d    = CLK_LEN'(INIT_PERIOD);
        period_ld_d = 1'b1;
        state_d     = ACQUIRE;
      end
      default: state_d = IDLE;
    endcase

    if (timeout) state_d = LOST;

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_300M) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      period_q    <= CLK_LEN'(INIT_PERIOD);
      period_ld_q <= 1'b0;
      clear_q     <= 1'b0;
      flip_q      <= 1'b0;
      type_q      <= 1'b0;
      locked_q    <= 1'b0;
      good_q      <= '0;
      slip_q      <= '0;
      sil_q       <= '0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      period_ld_q <= period_ld_d;
      clear_q     <= clear_d;
      flip_q      <= flip_d;
      type_q      <= type_d;
      locked_q    <= locked_d;
      good_q      <= good_d;
      slip_q      <= slip_d;
      sil_q       <= sil_d;
    end
  end

`ifdef RECCTRL_DRIFT_EN
  always_ff @(posedge clk_300M) begin
    if (!rst_n) drift_q <= '0;
    else        drift_q <= drift_d;
  end
`endif

  assign period_val = period_q;
  assign period_ld  = period_ld_q;
  assign clear_req  = clear_q;
  assign phase_flip = flip_q;
  assign type_sel   = type_q;
  assign locked     = locked_q;
  assign state      = state_q;

endmodule
